// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter family.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mul_arb_state_t;

    localparam int unsigned RR_MAX_N = 32;
    localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

    // First set bit of valid at or after ptr, wrapping modulo n; returns ptr when none set.
    function automatic int unsigned rr_pick(input logic [RR_MAX_N-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned sum;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            sum = ptr + k;
            if (sum >= n) sum = sum - n;
            if (k < n && !found) begin
                if (valid[RR_IDX_W'(sum)]) begin
                    found   = 1'b1;
                    rr_pick = sum;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mul.sv
// Signed fixed-point multiplier: 3-stage pipeline, half-to-even rounding, overflow flag.
module mul #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FBITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] val,
    output logic                    ovf
);
    localparam int unsigned      PW   = 2 * WIDTH;
    localparam logic [FBITS-1:0] HALF = FBITS'(1) << (FBITS - 1);

    logic signed [WIDTH-1:0] a_q, b_q;
    logic signed [PW-1:0]    prod_q, rnd_q, floor_c, rnd_c;
    logic [FBITS-1:0]        frac_c;
    logic                    up_c;
    logic [WIDTH:0]          top_c;
    logic                    s1_q, s2_q, s3_q;

    // Round the full product to FBITS fractional bits; ties go to the even neighbour.
    always_comb begin
        floor_c = prod_q >>> FBITS;
        frac_c  = prod_q[FBITS-1:0];
        up_c    = (frac_c > HALF) || ((frac_c == HALF) && floor_c[0]);
        rnd_c   = floor_c + PW'(up_c);
        top_c   = rnd_q[PW-1:WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            rnd_q  <= '0;
            val    <= '0;
            ovf    <= 1'b0;
        end else begin
            s1_q <= start;
            s2_q <= s1_q;
            s3_q <= s2_q;
            done <= s3_q;
            if (start) begin
                a_q  <= a;
                b_q  <= b;
                busy <= 1'b1;
            end else if (s3_q) begin
                busy <= 1'b0;
            end
            if (s1_q) prod_q <= PW'(a_q) * PW'(b_q);
            if (s2_q) rnd_q <= rnd_c;
            // Result wraps to WIDTH bits; ovf flags a rounded value outside the signed range.
            if (s3_q) begin
                val <= rnd_q[WIDTH-1:0];
                ovf <= !((&top_c) || !(|top_c));
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one mul between N requesters, tagged response with backpressure.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FBITS = 4,
    parameter int unsigned IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [WIDTH-1:0]   resp_val,
    output logic               resp_ovf,
    output logic               busy
);
    mul_arb_state_t state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, id_q, grant, ptr_next;
    logic           mul_start, mul_busy, mul_done, mul_ovf, capture;
    logic [WIDTH-1:0] mul_a, mul_b, mul_val;

    assign grant    = IDW'(rr_pick(RR_MAX_N'(req_valid), 32'(rr_ptr_q), N));
    assign ptr_next = (32'(grant) == N - 1) ? '0 : grant + IDW'(1);
    assign mul_a    = req_a[32'(grant)*WIDTH +: WIDTH];
    assign mul_b    = req_b[32'(grant)*WIDTH +: WIDTH];

    mul #(
        .WIDTH(WIDTH),
        .FBITS(FBITS)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(mul_start),
        .a    (mul_a),
        .b    (mul_b),
        .busy (mul_busy),
        .done (mul_done),
        .val  (mul_val),
        .ovf  (mul_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant is recomputed every IDLE cycle; ready only pulses on the winning lane.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        mul_start = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = N'(1) << grant;
                    mul_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (mul_done) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_val   <= '0;
            resp_ovf   <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (mul_start) begin
                id_q     <= grant;
                rr_ptr_q <= ptr_next;
            end
            if (capture) begin
                resp_valid <= 1'b1;
                resp_id    <= id_q;
                resp_val   <= mul_val;
                resp_ovf   <= mul_ovf;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_start_idle:   assert property (@(posedge clk) disable iff (rst) mul_start |-> !mul_busy);

endmodule
